// File: rtl/io_handshake_responder.sv
// Responder for the control core's INPUT / OUTPUT / PAUSE handshake: debounces the enter key,
// returns one-cycle acks and holds switch/display data. Optional auto-confirm: IO_TIMEOUT_EN.
module io_handshake_responder #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SWITCH_WIDTH    = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    is_input,
    input  logic                    is_output,
    input  logic                    enter_key,
    input  logic [SWITCH_WIDTH-1:0] switches,
    input  logic [DATA_WIDTH-1:0]   output_data,
    output logic                    confirmation,
    output logic                    continue_button,
    output logic [DATA_WIDTH-1:0]   input_data,
    output logic [DATA_WIDTH-1:0]   display_data,
    output logic                    waiting,
    output logic [1:0]              state_dbg
);

    // Handshake: the control core holds is_input/is_output as a level request until it sees
    // a one-cycle confirmation or continue_button pulse; dropping the level withdraws it.

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        ACK          = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    state_t                  r_state;
    logic                    r_key_s1;
    logic                    r_key_s2;
    logic                    r_stable;
    logic                    r_stable_d;
    logic [DB_W-1:0]         r_db_cnt;
    logic [SWITCH_WIDTH-1:0] r_sw_s1;
    logic [SWITCH_WIDTH-1:0] r_sw_s2;
    logic                    r_confirmation;
    logic                    r_continue;
    logic [DATA_WIDTH-1:0]   r_input_data;
    logic [DATA_WIDTH-1:0]   r_display_data;
    logic                    r_waiting;

    logic w_req;
    logic w_pause;
    logic w_in_only;
    logic w_out_only;
    logic w_press;
    logic w_advance;

    assign w_req      = is_input | is_output;
    assign w_pause    = is_input & is_output;
    assign w_in_only  = is_input & ~is_output;
    assign w_out_only = is_output & ~is_input;
    assign w_press    = r_stable & ~r_stable_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_key_s1   <= 1'b0;
            r_key_s2   <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_db_cnt   <= '0;
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
        end else begin
            r_key_s1   <= enter_key;
            r_key_s2   <= r_key_s1;
            r_stable_d <= r_stable;
            r_sw_s1    <= switches;
            r_sw_s2    <= r_sw_s1;
            // Any return to the accepted level restarts the stability window.
            if (r_key_s2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_db_cnt <= '0;
                r_stable <= r_key_s2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;

    assign w_timeout = (r_to_cnt == TO_MAX);
    assign w_advance = w_press | w_timeout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_state == WAIT_PRESS && w_req && !w_advance) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign w_advance = w_press;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_confirmation <= 1'b0;
            r_continue     <= 1'b0;
            r_input_data   <= '0;
            r_display_data <= '0;
            r_waiting      <= 1'b0;
        end else begin
            r_confirmation <= 1'b0;
            r_continue     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state   <= WAIT_PRESS;
                        r_waiting <= 1'b1;
                        if (w_out_only) begin
                            r_display_data <= output_data;
                        end
                    end
                end
                WAIT_PRESS: begin
                    // A dropped request beats a coincident press.
                    if (!w_req) begin
                        r_state   <= IDLE;
                        r_waiting <= 1'b0;
                    end else if (w_advance) begin
                        r_state        <= ACK;
                        r_waiting      <= 1'b0;
                        r_confirmation <= ~w_pause;
                        r_continue     <= w_pause;
                        if (w_in_only) begin
                            r_input_data <= DATA_WIDTH'(r_sw_s2);
                        end
                    end
                end
                ACK: begin
                    r_state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!r_stable) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_waiting <= 1'b0;
                end
            endcase
        end
    end

    assign confirmation    = r_confirmation;
    assign continue_button = r_continue;
    assign input_data      = r_input_data;
    assign display_data    = r_display_data;
    assign waiting         = r_waiting;
    assign state_dbg       = r_state;

endmodule

// File: tb/tb_io_handshake_responder.sv
// Self-checking bench for io_handshake_responder: directed requests and key presses,
// an expected-ack queue and a negedge monitor. Covers the IO_TIMEOUT_EN build too.
module tb_io_handshake_responder;

  localparam int DB = 4;
  localparam int TO = 16;
  localparam int SW = 16;
  localparam int DW = 32;
  localparam int EW = 2 + 2 * DW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          is_input = 1'b0;
  logic          is_output = 1'b0;
  logic          enter_key = 1'b0;
  logic [SW-1:0] switches = '0;
  logic [DW-1:0] output_data = '0;
  logic          confirmation;
  logic          continue_button;
  logic [DW-1:0] input_data;
  logic [DW-1:0] display_data;
  logic          waiting;
  logic [1:0]    state_dbg;

  io_handshake_responder #(
    .DEBOUNCE_CYCLES(DB),
    .SWITCH_WIDTH   (SW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .is_input       (is_input),
    .is_output      (is_output),
    .enter_key      (enter_key),
    .switches       (switches),
    .output_data    (output_data),
    .confirmation   (confirmation),
    .continue_button(continue_button),
    .input_data     (input_data),
    .display_data   (display_data),
    .waiting        (waiting),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] exp_in = '0;
  logic [DW-1:0] exp_disp = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // scoreboard monitor: every ack pulse cycle must match the head of the queue
  always @(negedge clock) begin
    logic [EW-1:0] e;
    logic [EW-1:0] g;
    if (reset && (confirmation || continue_button)) begin
      n_checks++;
      g = {confirmation, continue_button, input_data, display_data};
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_ack: conf=%0b cont=%0b in=%0h disp=%0h",
                 confirmation, continue_button, input_data, display_data);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_errors++;
          $display("FAIL ack: got conf=%0b cont=%0b in=%0h disp=%0h expected conf=%0b cont=%0b in=%0h disp=%0h",
                   g[EW-1], g[EW-2], g[2*DW-1:DW], g[DW-1:0],
                   e[EW-1], e[EW-2], e[2*DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_ack(input logic conf, input logic cont);
    exp_q.push_back({conf, cont, exp_in, exp_disp});
  endtask

  // The control core drops its request when it sees the ack.
  task automatic press_hold(input int hold);
    enter_key = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step(1);
      if (confirmation || continue_button) begin
        is_input  = 1'b0;
        is_output = 1'b0;
      end
    end
  endtask

  task automatic release_key();
    enter_key = 1'b0;
    step(12);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_waiting"}, waiting, 0);
    check({tag, "_input_data"}, input_data, exp_in);
    check({tag, "_display_data"}, display_data, exp_disp);
    check({tag, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    int k;
    int got_k;
    // reset
    step(1);
    check("rst_conf", confirmation, 0);
    check("rst_cont", continue_button, 0);
    check("rst_in", input_data, 0);
    check("rst_disp", display_data, 0);
    check("rst_waiting", waiting, 0);
    check("rst_state", state_dbg, 0);
    step(2);
    reset = 1'b1;
    step(2);

    // 1. INPUT with switches 16'hBEEF
    switches = 16'hBEEF;
    is_input = 1'b1;
    step(2);
    check("t1_waiting", waiting, 1);
    exp_in = 32'h0000BEEF;
    push_ack(1'b1, 1'b0);
    press_hold(10);
    release_key();
    check_idle_outputs("t1");

    // 2. OUTPUT: display updates before any press
    output_data = 32'h12345678;
    is_output = 1'b1;
    step(1);
    check("t2_display_early", display_data, 32'h12345678);
    check("t2_waiting", waiting, 1);
    exp_disp = 32'h12345678;
    push_ack(1'b1, 1'b0);
    press_hold(10);
    release_key();
    check_idle_outputs("t2");

`ifndef IO_TIMEOUT_EN
    // 3. PAUSE with the key already held
    switches = 16'h0F0F;
    output_data = 32'hDEADBEEF;
    enter_key = 1'b1;
    step(12);
    is_input = 1'b1;
    is_output = 1'b1;
    step(20);
    check("t3_held_waiting", waiting, 1);
    check("t3_held_queue", exp_q.size(), 0);
    release_key();
    push_ack(1'b0, 1'b1);
    press_hold(10);
    release_key();
    check_idle_outputs("t3");

    // 4. Bounce never acks, then drop the request
    switches = 16'h5555;
    is_input = 1'b1;
    step(2);
    for (int i = 0; i < 10; i++) begin
      enter_key = ~enter_key;
      step(2);
    end
    enter_key = 1'b0;
    step(12);
    check("t4_bounce_waiting", waiting, 1);
    is_input = 1'b0;
    step(2);
    check("t4_drop_state", state_dbg, 0);
    check_idle_outputs("t4");

    // 7. No timeout in the default build
    is_input = 1'b1;
    step(100);
    check("t7_still_waiting", waiting, 1);
    is_input = 1'b0;
    step(2);
    check_idle_outputs("t7");
`endif

    // 5. Reset while in WAIT_RELEASE
    switches = 16'h1234;
    is_input = 1'b1;
    step(2);
    exp_in = 32'h00001234;
    push_ack(1'b1, 1'b0);
    press_hold(10);
    check("t5_wait_release", state_dbg, 3);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_conf", confirmation, 0);
    check("t5_rst_cont", continue_button, 0);
    check("t5_rst_in", input_data, 0);
    check("t5_rst_disp", display_data, 0);
    check("t5_rst_waiting", waiting, 0);
    check("t5_rst_state", state_dbg, 0);
    exp_in = '0;
    exp_disp = '0;
    step(2);
    reset = 1'b1;
    release_key();
    press_hold(10);
    release_key();
    step(10);
    check_idle_outputs("t5");

`ifdef IO_TIMEOUT_EN
    // 6. Timeout auto-confirm, 17 cycles after WAIT_PRESS entry
    switches = 16'h00A5;
    is_input = 1'b1;
    exp_in = 32'h000000A5;
    push_ack(1'b1, 1'b0);
    step(1);
    got_k = 0;
    for (k = 1; k <= 40; k++) begin
      step(1);
      if (confirmation) begin
        got_k = k;
        is_input = 1'b0;
        break;
      end
    end
    check("t6_timeout_cycles", got_k, 17);
    step(4);
    check_idle_outputs("t6");
`endif

    // report
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
